// File: rtl/snake_px_pkg.sv
// Shared types and helpers for the snake pixel-write responder.
// px_req_t is one buffered pixel write; rd_state_t is the read FSM state;
// to_linear() maps {y,x} screen coordinates onto the linear RAM index.
package snake_px_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;
  localparam int NUM_X  = 320;
  localparam int NUM_Y  = 240;

  typedef struct packed {
    logic [8:0]        x;
    logic [7:0]        y;
    logic [DATA_W-1:0] data;
  } px_req_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } rd_state_t;

  // y*320 + x built from shifts; cannot overflow 17 bits for any 9/8-bit input
  function automatic logic [ADDR_W-1:0] to_linear(input logic [8:0] x, input logic [7:0] y);
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] x_ext;
    y_ext     = {9'd0, y};
    x_ext     = {8'd0, x};
    to_linear = (y_ext << 8) + (y_ext << 6) + x_ext;
  endfunction

endpackage

// File: rtl/px_fifo.sv
// Small synchronous FIFO of px_req_t entries with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Storage is not reset; only the pointers are.
module px_fifo
  import snake_px_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  px_req_t push_data,
  input  logic    pop,
  output px_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  px_req_t     store [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr[AW-1:0]];

  // advance read/write pointers; a push into a full FIFO is refused
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // entry storage
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/snake_px_responder.sv
// Avalon-MM slave for snake pixel writes/reads into a 320x240x16 frame buffer.
// Writes are buffered in px_fifo and drained one per cycle while the read FSM
// is idle; a read starts only once the FIFO is empty and the last RAM write
// strobe has retired, so reads always observe earlier writes.
// Optional build macro SNAKE_PX_STATS_EN adds stat_wr_cnt / stat_drop_cnt.
module snake_px_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int X_LSB      = 1,
  parameter int Y_LSB      = 10,
  parameter int NUM_X      = snake_px_pkg::NUM_X,
  parameter int NUM_Y      = snake_px_pkg::NUM_Y
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] av_address,
  input  logic        av_read,
  input  logic        av_write,
  input  logic [15:0] av_writedata,
  output logic        av_waitrequest,
  output logic [15:0] av_readdata,
  output logic [16:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef SNAKE_PX_STATS_EN
  ,
  output logic [31:0] stat_wr_cnt,
  output logic [15:0] stat_drop_cnt
`endif
);

  import snake_px_pkg::*;

  localparam logic [8:0]  X_LIM     = 9'(NUM_X);
  localparam logic [7:0]  Y_LIM     = 8'(NUM_Y);
  localparam logic [31:0] USED_MASK = (32'h1FF << X_LSB) | (32'hFF << Y_LSB);

  logic [8:0] x_in;
  logic [7:0] y_in;
  logic       in_range;
  logic       unused_addr;
  logic       full;
  logic       empty;
  logic       wr_accept;
  logic       push;
  logic       drop;
  logic       pop;
  logic       rd_start;
  logic       rd_ok;
  px_req_t    push_req;
  px_req_t    pop_req;
  rd_state_t  state;
  rd_state_t  next_state;

  assign x_in        = av_address[X_LSB +: 9];
  assign y_in        = av_address[Y_LSB +: 8];
  assign in_range    = (x_in < X_LIM) && (y_in < Y_LIM);
  assign unused_addr = ^(av_address & ~USED_MASK);

  // a simultaneous read+write is handled as a write; the read is ignored
  assign wr_accept = av_write && !full;
  assign push      = wr_accept && in_range;
  assign drop      = wr_accept && !in_range;
  assign pop       = (state == IDLE) && !empty;
  assign rd_start  = (state == IDLE) && av_read && !av_write && empty && !mem_we;

  assign push_req.x    = x_in;
  assign push_req.y    = y_in;
  assign push_req.data = av_writedata;

  px_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_req),
    .pop      (pop),
    .pop_data (pop_req),
    .full     (full),
    .empty    (empty)
  );

  // read FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // read FSM sequencing; once started it always runs to completion
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (rd_start) next_state = RD_ISSUE;
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  next_state = RD_DONE;
      RD_DONE:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // stall writes while the FIFO is full, stall reads until the FSM reaches RD_DONE
  always_comb begin
    av_waitrequest = 1'b0;
    if (av_write)     av_waitrequest = full;
    else if (av_read) av_waitrequest = (state != RD_DONE);
  end

  // commit stage: RAM strobe/address/data from the FIFO head, read address issue, read data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      av_readdata <= '0;
      rd_ok       <= 1'b0;
    end else begin
      mem_we <= pop;
      if (pop) begin
        mem_addr  <= to_linear(pop_req.x, pop_req.y);
        mem_wdata <= pop_req.data;
      end else if (rd_start && in_range) begin
        mem_addr  <= to_linear(x_in, y_in);
      end
      if (rd_start) rd_ok <= in_range;
      if (state == RD_WAIT) av_readdata <= rd_ok ? mem_rdata : 16'h0000;
    end
  end

`ifdef SNAKE_PX_STATS_EN
  // wrap-around counters of committed and out-of-range writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_wr_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (pop)  stat_wr_cnt   <= stat_wr_cnt + 32'd1;
      if (drop) stat_drop_cnt <= stat_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snake_px_responder.sv
// Directed bench for snake_px_responder with a write scoreboard and a
// behavioural frame-buffer RAM. A second instance with a 2-entry FIFO
// exercises waitrequest backpressure.
module tb_snake_px_responder;

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic        av_waitrequest;
  logic [15:0] av_readdata;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [31:0] b_address;
  logic        b_read;
  logic        b_write;
  logic [15:0] b_wdata;
  logic        b_wait;
  logic [15:0] b_readdata;
  logic [16:0] b_maddr;
  logic        b_mwe;
  logic [15:0] b_mwdata;
  logic [15:0] b_rdata;

`ifdef SNAKE_PX_STATS_EN
  logic [31:0] stat_wr_cnt;
  logic [15:0] stat_drop_cnt;
  logic [31:0] b_stat_wr;
  logic [15:0] b_stat_drop;
`endif

  snake_px_responder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .av_address(av_address), .av_read(av_read),
    .av_write(av_write), .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef SNAKE_PX_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
  );

  snake_px_responder #(.FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .av_address(b_address), .av_read(b_read),
    .av_write(b_write), .av_writedata(b_wdata), .av_waitrequest(b_wait),
    .av_readdata(b_readdata), .mem_addr(b_maddr), .mem_we(b_mwe),
    .mem_wdata(b_mwdata), .mem_rdata(b_rdata)
`ifdef SNAKE_PX_STATS_EN
    , .stat_wr_cnt(b_stat_wr), .stat_drop_cnt(b_stat_drop)
`endif
  );

  assign b_rdata = 16'h1234;

  // frame-buffer RAM model: synchronous write, one-cycle read latency
  logic [15:0] ram [0:131071];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int          checks = 0;
  int          failures = 0;
  int          n_commits = 0;
  int          n_expect = 0;
  wr_exp_t     sb_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] exp_mem [int];

  function automatic logic [31:0] addr_of(input int x, input int y);
    return (32'(y) << 10) | (32'(x) << 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    wr_exp_t e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      n_commits++;
      if (sb_q.size() == 0) begin
        check("unexpected_mem_we", {31'd0, mem_we}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("mem_addr", 32'(mem_addr), 32'(e.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic do_write(input int x, input int y, input logic [15:0] d, output int stalls);
    wr_exp_t e;
    av_address   = addr_of(x, y);
    av_writedata = d;
    av_write     = 1'b1;
    #1;
    stalls = 0;
    while (av_waitrequest === 1'b1 && stalls < 20) begin
      tick();
      stalls++;
    end
    if (av_waitrequest !== 1'b0) check("write_accept_timeout", {31'd0, av_waitrequest}, 32'd0);
    if (x < 320 && y < 240) begin
      e.addr = 17'(y * 320 + x);
      e.data = d;
      sb_q.push_back(e);
      exp_mem[y * 320 + x] = d;
      n_expect++;
    end
    tick();
    av_write = 1'b0;
  endtask

  task automatic do_read(input int x, input int y, output int lat);
    logic [15:0] exp;
    av_address = addr_of(x, y);
    av_read    = 1'b1;
    exp = 16'h0000;
    if (x < 320 && y < 240 && exp_mem.exists(y * 320 + x)) exp = exp_mem[y * 320 + x];
    rd_q.push_back(exp);
    #1;
    lat = 0;
    while (av_waitrequest === 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (av_waitrequest !== 1'b0) check("read_timeout", {31'd0, av_waitrequest}, 32'd0);
    exp = rd_q.pop_front();
    check("av_readdata", 32'(av_readdata), 32'(exp));
    tick();
    av_read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    int lat;
    int total_st;
    reset = 1'b1;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
    b_address = '0;  b_read = 1'b0;  b_write = 1'b0;  b_wdata = '0;
    tick();
    tick();
    check("rst_waitrequest", {31'd0, av_waitrequest}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_readdata", 32'(av_readdata), 32'd0);
    check("rst_b_outputs", {b_wait, b_mwe, b_maddr, b_mwdata[12:0]}, 32'd0);
    check("rst_b_readdata", 32'(b_readdata), 32'd0);
`ifdef SNAKE_PX_STATS_EN
    check("rst_b_stats", b_stat_wr | 32'(b_stat_drop), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // single write, empty FIFO: strobe two cycles after presentation
    do_write(5, 3, 16'hF800, st);
    check("wr_no_stall", 32'(st), 32'd0);
    check("we_not_yet", {31'd0, mem_we}, 32'd0);
    tick();
    check("we_two_cycles", {31'd0, mem_we}, 32'd1);
    check("we_addr_965", 32'(mem_addr), 32'd965);

    // out-of-range writes are accepted and dropped
    do_write(320, 0, 16'h1111, st);
    do_write(0, 240, 16'h2222, st);
    repeat (4) tick();
    check("drop_no_commit", 32'(n_commits), 32'(n_expect));
`ifdef SNAKE_PX_STATS_EN
    check("stat_drop_cnt", 32'(stat_drop_cnt), 32'd2);
    check("stat_wr_cnt", stat_wr_cnt, 32'd1);
`endif

    // read right behind a write must return the new colour
    do_write(10, 10, 16'h07E0, st);
    do_read(10, 10, lat);
    check("raw_latency", 32'(lat), 32'd5);
    do_read(5, 3, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_addr", 32'(mem_addr), 32'd965);

    // out-of-range read: zero data, RAM address untouched
    do_read(400, 1, lat);
    check("oor_rd_latency", 32'(lat), 32'd3);
    check("oor_rd_addr_kept", 32'(mem_addr), 32'd965);

    // five back-to-back writes while an abandoned read holds off draining
    av_address = addr_of(1, 1);
    av_read = 1'b1;
    tick();
    av_read = 1'b0;
    total_st = 0;
    for (int i = 0; i < 5; i++) begin
      do_write(30 + i, 7, 16'hA000 + 16'(i), st);
      total_st += st;
    end
    check("depth4_no_stall", 32'(total_st), 32'd0);
    repeat (10) tick();
    check("burst_all_committed", 32'(sb_q.size()), 32'd0);
    check("burst_commit_count", 32'(n_commits), 32'(n_expect));
    do_read(32, 7, lat);

    // backpressure on the 2-entry instance
    b_address = addr_of(0, 0);
    b_read = 1'b1;
    tick();
    b_read = 1'b0; b_write = 1'b1; b_address = addr_of(2, 2); b_wdata = 16'hB001;
    #1 check("bp_w1_accept", {31'd0, b_wait}, 32'd0);
    tick();
    b_wdata = 16'hB002;
    #1 check("bp_w2_accept", {31'd0, b_wait}, 32'd0);
    tick();
    b_wdata = 16'hB003;
    #1 check("bp_full_stall", {31'd0, b_wait}, 32'd1);
    tick();
    #1 check("bp_full_before_pop", {31'd0, b_wait}, 32'd1);
    check("bp_no_we_yet", {31'd0, b_mwe}, 32'd0);
    tick();
    #1 check("bp_release", {31'd0, b_wait}, 32'd0);
    check("bp_we1", {31'd0, b_mwe}, 32'd1);
    check("bp_data1", 32'(b_mwdata), 32'hB001);
    tick();
    b_write = 1'b0;
    #1 check("bp_data2", 32'(b_mwdata), 32'hB002);
    tick();
    check("bp_data3", 32'(b_mwdata), 32'hB003);
    check("bp_addr3", 32'(b_maddr), 32'd642);
    tick();
    check("bp_drained", {31'd0, b_mwe}, 32'd0);

    // reset with three writes queued: all lost
    av_address = addr_of(1, 1);
    av_read = 1'b1;
    tick();
    av_read = 1'b0;
    av_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      av_address = addr_of(20 + i, 20);
      av_writedata = 16'hC000 + 16'(i);
      tick();
    end
    av_write = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_waitrequest", {31'd0, av_waitrequest}, 32'd0);
    check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("midrst_nothing_committed", 32'(n_commits), 32'(n_expect));
    do_write(7, 7, 16'h1234, st);
    check("post_rst_we_early", {31'd0, mem_we}, 32'd0);
    tick();
    check("post_rst_we", {31'd0, mem_we}, 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'd2247);
    repeat (3) tick();
    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
`ifdef SNAKE_PX_STATS_EN
    check("stat_wr_after_rst", stat_wr_cnt, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
